// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Front-end controller for the combinational ALU. Collects operand A,
//   operand B and an operation from debounced switches/buttons, drives the
//   ALU for a single evaluation cycle, then latches and holds the result.
//
// Parameters
//   bits      operand width; ALU result width is bits+1
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   value     in   operand from switches, sampled on an enter press
//   enter     in   debounced enter level
//   op_btn    in   debounced op levels {add, sub, or, and}
//   clear     in   synchronous abort to GET_A (results retained)
//   alu_res   in   ALU result
//   alu_ok    in   ALU "result fits" flag
//   alu_a     out  registered operand A
//   alu_b     out  registered operand B
//   alu_op    out  one-hot operation, non-zero only during EXEC
//   result    out  latched ALU result
//   overflow  out  latched ~alu_ok
//   done      out  one-cycle pulse when result updates
//   state     out  GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4
//
// Build option
//   ALU_SEQ_CHAIN_EN  when defined, an op press in SHOW reuses the result as
//                     operand A and the op is applied right after B is entered.

module alu_sequencer #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [bits-1:0] value,
    input  logic            enter,
    input  logic [3:0]      op_btn,
    input  logic            clear,
    input  logic [bits:0]   alu_res,
    input  logic            alu_ok,
    output logic [bits-1:0] alu_a,
    output logic [bits-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [bits:0]   result,
    output logic            overflow,
    output logic            done,
    output logic [2:0]      state
);

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_SHOW   = 3'd4;

    // True when exactly one bit of the op vector is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic       enter_prev_r;
    logic [3:0] op_prev_r;
    logic [3:0] op_r;
    logic       enter_press_s;
    logic       op_press_s;
    logic       chain_op_s;
    logic       chain_pending_s;
    logic       load_a_s;
    logic       load_a_chain_s;
    logic       load_b_s;
    logic       load_op_s;
    logic       latch_res_s;
    logic [3:0] alu_op_next_s;

    // A press is a rising edge; an op press also needs a clean one-hot vector
    assign enter_press_s = enter & ~enter_prev_r;
    assign op_press_s    = (|(op_btn & ~op_prev_r)) & is_onehot4(op_btn);

`ifdef ALU_SEQ_CHAIN_EN
    logic chain_r;

    // Enter takes precedence over an op press in SHOW
    assign chain_op_s      = (state_r == S_SHOW) & op_press_s & ~enter_press_s;
    assign chain_pending_s = chain_r;

    // Remembers that the op is already latched so GET_B can skip GET_OP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_r <= 1'b0;
        end else if (clear) begin
            chain_r <= 1'b0;
        end else if (chain_op_s) begin
            chain_r <= 1'b1;
        end else if ((state_r == S_GET_B) && enter_press_s) begin
            chain_r <= 1'b0;
        end else begin
            chain_r <= chain_r;
        end
    end
`else
    assign chain_op_s      = 1'b0;
    assign chain_pending_s = 1'b0;
`endif

    // State register and button edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_GET_A;
            enter_prev_r <= 1'b0;
            op_prev_r    <= 4'b0000;
        end else begin
            state_r      <= next_state_s;
            enter_prev_r <= enter;
            op_prev_r    <= op_btn;
        end
    end

    // Next-state logic; clear overrides every press
    always_comb begin
        next_state_s = state_r;
        if (clear) begin
            next_state_s = S_GET_A;
        end else begin
            case (state_r)
                S_GET_A: begin
                    if (enter_press_s) next_state_s = S_GET_B;
                    else               next_state_s = state_r;
                end
                S_GET_B: begin
                    if (enter_press_s) next_state_s = chain_pending_s ? S_EXEC : S_GET_OP;
                    else               next_state_s = state_r;
                end
                S_GET_OP: begin
                    if (op_press_s) next_state_s = S_EXEC;
                    else            next_state_s = state_r;
                end
                S_EXEC: begin
                    next_state_s = S_SHOW;
                end
                S_SHOW: begin
                    if (enter_press_s)   next_state_s = S_GET_A;
                    else if (chain_op_s) next_state_s = S_GET_B;
                    else                 next_state_s = state_r;
                end
                default: begin
                    next_state_s = S_GET_A;
                end
            endcase
        end
    end

    // Load enables for the datapath registers
    always_comb begin
        load_a_s       = ~clear & (state_r == S_GET_A) & enter_press_s;
        load_a_chain_s = ~clear & chain_op_s;
        load_b_s       = ~clear & (state_r == S_GET_B) & enter_press_s;
        load_op_s      = ~clear & (((state_r == S_GET_OP) & op_press_s) | chain_op_s);
        latch_res_s    = ~clear & (state_r == S_EXEC);
        // alu_op is registered, so it is prepared on the edge entering EXEC
        if (next_state_s == S_EXEC) begin
            if (state_r == S_GET_OP) alu_op_next_s = op_btn;
            else                     alu_op_next_s = op_r;
        end else begin
            alu_op_next_s = 4'b0000;
        end
    end

    // Operand, op, result and done registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a    <= {bits{1'b0}};
            alu_b    <= {bits{1'b0}};
            op_r     <= 4'b0000;
            alu_op   <= 4'b0000;
            result   <= {(bits+1){1'b0}};
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load_a_s)            alu_a <= value;
            else if (load_a_chain_s) alu_a <= result[bits-1:0];
            else                     alu_a <= alu_a;
            if (load_b_s) alu_b <= value;
            else          alu_b <= alu_b;
            if (load_op_s) op_r <= op_btn;
            else           op_r <= op_r;
            alu_op <= alu_op_next_s;
            if (latch_res_s) begin
                result   <= alu_res;
                overflow <= ~alu_ok;
            end else begin
                result   <= result;
                overflow <= overflow;
            end
            done <= latch_res_s;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int BITS = 8;

    logic            clk;
    logic            reset_n;
    logic [BITS-1:0] value;
    logic            enter;
    logic [3:0]      op_btn;
    logic            clear;
    logic [BITS:0]   alu_res;
    logic            alu_ok;
    logic [BITS-1:0] alu_a;
    logic [BITS-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [BITS:0]   result;
    logic            overflow;
    logic            done;
    logic [2:0]      state;

    int checks = 0;
    int passes = 0;
    int done_count = 0;

    alu_sequencer #(.bits(BITS)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .enter(enter),
        .op_btn(op_btn), .clear(clear), .alu_res(alu_res), .alu_ok(alu_ok),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .result(result),
        .overflow(overflow), .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {ok, res}
    function automatic logic [9:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
        int r;
        logic ok;
        case (op)
            4'b1000: r = int'(a) + int'(b);
            4'b0100: r = (int'(a) - int'(b)) & 511;
            4'b0010: r = int'(a | b);
            4'b0001: r = int'(a & b);
            default: r = 0;
        endcase
        ok = (op != 4'b0000) && (r < 256);
        return {ok, r[8:0]};
    endfunction

    // ALU environment seen by the DUT
    always_comb {alu_ok, alu_res} = model_alu(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of the sequencer
    logic [2:0] m_state;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op, m_lop, m_pop;
    logic [8:0] m_res;
    logic       m_ovf, m_done, m_chain, m_pe;
    logic       m_ep, m_valid;
    logic [9:0] m_alu;

    assign m_ep    = enter & ~m_pe;
    assign m_valid = (|(op_btn & ~m_pop)) && ($countones(op_btn) == 1);
    assign m_alu   = model_alu(m_a, m_b, m_op);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 3'd0; m_a <= 8'd0; m_b <= 8'd0; m_op <= 4'd0; m_lop <= 4'd0;
            m_pop <= 4'd0; m_res <= 9'd0; m_ovf <= 1'b0; m_done <= 1'b0;
            m_chain <= 1'b0; m_pe <= 1'b0;
        end else begin
            m_pe   <= enter;
            m_pop  <= op_btn;
            m_done <= 1'b0;
            m_op   <= 4'd0;
            if (clear) begin
                m_state <= 3'd0;
                m_chain <= 1'b0;
            end else begin
                case (m_state)
                    3'd0: if (m_ep) begin m_a <= value; m_state <= 3'd1; end
                    3'd1: if (m_ep) begin
                        m_b <= value;
                        if (m_chain) begin m_state <= 3'd3; m_op <= m_lop; m_chain <= 1'b0; end
                        else m_state <= 3'd2;
                    end
                    3'd2: if (m_valid) begin m_lop <= op_btn; m_op <= op_btn; m_state <= 3'd3; end
                    3'd3: begin
                        m_res <= m_alu[8:0]; m_ovf <= ~m_alu[9]; m_done <= 1'b1; m_state <= 3'd4;
                    end
                    3'd4: begin
                        if (m_ep) m_state <= 3'd0;
`ifdef ALU_SEQ_CHAIN_EN
                        else if (m_valid) begin
                            m_a <= m_res[7:0]; m_lop <= op_btn; m_chain <= 1'b1; m_state <= 3'd1;
                        end
`endif
                    end
                    default: m_state <= 3'd0;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("state", 32'(state), 32'(m_state));
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("result", 32'(result), 32'(m_res));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("done", 32'(done), 32'(m_done));
        if (done) done_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_enter(input logic [7:0] v);
        value = v; enter = 1'b1; tick(1);
        enter = 1'b0; tick(1);
    endtask

    task automatic press_op(input logic [3:0] o);
        op_btn = o; tick(1);
        op_btn = 4'b0000; tick(1);
    endtask

    initial begin
        reset_n = 1'b0; value = 8'd0; enter = 1'b0; op_btn = 4'b0000; clear = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // 200 + 100 with overflow; done two edges after the op press edge
        press_enter(8'd200);
        press_enter(8'd100);
        op_btn = 4'b1000; tick(1);
        check("add_exec_state", 32'(state), 32'd3);
        check("add_exec_op", 32'(alu_op), 32'h8);
        op_btn = 4'b0000; tick(1);
        check("add_done", 32'(done), 32'd1);
        check("add_result", 32'(result), 32'h12C);
        check("add_ovf", 32'(overflow), 32'd1);
        tick(1);
        check("add_done_low", 32'(done), 32'd0);
        press_enter(8'd0);

        // 5 - 10 wraps to 9'h1FB
        press_enter(8'd5);
        press_enter(8'd10);
        press_op(4'b0100);
        check("sub_result", 32'(result), 32'h1FB);
        check("sub_ovf", 32'(overflow), 32'd1);
        press_enter(8'd0);

        // 12 & 10 = 8
        press_enter(8'd12);
        press_enter(8'd10);
        press_op(4'b0001);
        check("and_result", 32'(result), 32'd8);
        check("and_ovf", 32'(overflow), 32'd0);
        press_enter(8'd0);

        // Held enter produces one transition only
        value = 8'd7; enter = 1'b1; tick(10);
        enter = 1'b0; tick(1);
        check("hold_state", 32'(state), 32'd1);
        check("hold_a", 32'(alu_a), 32'd7);

        // Clear beats enter in GET_B
        clear = 1'b1; enter = 1'b1; value = 8'd99; tick(1);
        clear = 1'b0; enter = 1'b0;
        check("clr_state", 32'(state), 32'd0);
        check("clr_b", 32'(alu_b), 32'd10);
        check("clr_done", 32'(done), 32'd0);
        tick(1);

        // Multi-hot op is ignored, then reset during EXEC
        press_enter(8'd1);
        press_enter(8'd2);
        op_btn = 4'b1100; tick(1);
        check("multihot_state", 32'(state), 32'd2);
        op_btn = 4'b0000; tick(1);
        op_btn = 4'b0010; tick(1);
        check("or_exec_state", 32'(state), 32'd3);
        reset_n = 1'b0; #1;
        check("rst_exec_state", 32'(state), 32'd0);
        check("rst_exec_a", 32'(alu_a), 32'd0);
        check("rst_exec_op", 32'(alu_op), 32'd0);
        check("rst_exec_result", 32'(result), 32'd0);
        op_btn = 4'b0000;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("done_count", 32'(done_count), 32'd3);

        // Op press in SHOW
        press_enter(8'd20);
        press_enter(8'd10);
        press_op(4'b1000);
        check("r30", 32'(result), 32'd30);
        press_op(4'b1000);
`ifdef ALU_SEQ_CHAIN_EN
        check("chain_state", 32'(state), 32'd1);
        check("chain_a", 32'(alu_a), 32'd30);
        press_enter(8'd5);
        check("chain_result", 32'(result), 32'd35);
        check("chain_done", 32'(done), 32'd1);
`else
        check("nochain_state", 32'(state), 32'd4);
        check("nochain_result", 32'(result), 32'd30);
`endif
        tick(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
